// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the picosoc iomem bus, one transaction in flight,
// with a bus timeout that completes the stalled master with a marker read value.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT       = 64,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  input  logic        timeout_clr,
  output logic        timeout_flag,
  output logic        timeout_master,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] count;

  logic        sel_valid;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        expired;
  logic [31:0] done_rdata;

  always_comb begin
    sel_valid  = grant ? m1_valid : m0_valid;
    sel_wstrb  = grant ? m1_wstrb : m0_wstrb;
    sel_addr   = grant ? m1_addr  : m0_addr;
    sel_wdata  = grant ? m1_wdata : m0_wdata;
    expired    = (count == LAST_COUNT);
    done_rdata = s_ready ? s_rdata : TIMEOUT_RDATA;
  end

  // Target side is quiet outside BUSY so the decode never sees a stale address.
  always_comb begin
    s_valid = (state == BUSY);
    s_wstrb = s_valid ? sel_wstrb : 4'b0000;
    s_addr  = s_valid ? sel_addr  : 32'h0;
    s_wdata = s_valid ? sel_wdata : 32'h0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      grant          <= 1'b1;
      count          <= 16'h0;
      m0_ready       <= 1'b0;
      m1_ready       <= 1'b0;
      m0_rdata       <= 32'h0;
      m1_rdata       <= 32'h0;
      timeout_flag   <= 1'b0;
      timeout_master <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      if (timeout_clr)
        timeout_flag <= 1'b0;

      case (state)
        IDLE: begin
          count <= 16'h0;
          // Under contention the master that did not hold the last grant goes next.
          if (m0_valid && m1_valid) begin
            grant <= ~grant;
            state <= BUSY;
          end else if (m0_valid) begin
            grant <= 1'b0;
            state <= BUSY;
          end else if (m1_valid) begin
            grant <= 1'b1;
            state <= BUSY;
          end
        end

        BUSY: begin
          if (!sel_valid) begin
            state <= IDLE;
          end else if (s_ready || expired) begin
            if (grant) begin
              m1_rdata <= done_rdata;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= done_rdata;
              m0_ready <= 1'b1;
            end
            // A target answering on the last allowed cycle still counts as a real completion.
            if (!s_ready) begin
              timeout_flag   <= 1'b1;
              timeout_master <= grant;
            end
            state <= DONE;
          end else begin
            count <= count + 16'h1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter: stimulus queues expected target requests and
// master completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_iomem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
  logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
  logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = 32'h0;
  logic        timeout_clr = 1'b0;
  logic        timeout_flag, timeout_master, grant;

  iomem_arbiter #(.TIMEOUT(64), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_clr(timeout_clr), .timeout_flag(timeout_flag),
    .timeout_master(timeout_master), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct { int m; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { logic g; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } req_t;

  rsp_t exp_rsp[$];
  req_t exp_req[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Target model knobs, written by the main flow only while the bus is idle.
  int          tgt_delay = 1;
  bit          tgt_never = 1'b0;
  bit          tgt_fixed = 1'b0;
  logic [31:0] tgt_rdata = 32'h0;
  bit          tgt_late  = 1'b0;

  initial forever @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectReq(input logic g, input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    req_t q;
    q.g = g; q.addr = addr; q.wstrb = wstrb; q.wdata = wdata;
    exp_req.push_back(q);
  endtask

  task automatic expectRsp(input int m, input logic [31:0] rdata, input int at_cyc);
    rsp_t r;
    r.m = m; r.rdata = rdata; r.cyc = at_cyc;
    exp_rsp.push_back(r);
  endtask

  // One master transaction: raise valid, hold until ready, drop valid in the DONE cycle.
  task automatic applyStimulus(input int m, input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    bit seen = 1'b0;
    @(posedge clk); #1;
    if (m == 0) begin
      m0_valid = 1'b1; m0_addr = addr; m0_wstrb = wstrb; m0_wdata = wdata;
    end else begin
      m1_valid = 1'b1; m1_addr = addr; m1_wstrb = wstrb; m1_wdata = wdata;
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (m == 0) ? m0_ready : m1_ready;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL req_wait_m%0d: ready never seen, required within 200 cycles", m);
    end
    if (m == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  // Target: answers tgt_delay cycles after s_valid rises, or never; tgt_late injects a stray ready.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (tgt_late) begin
        s_ready = 1'b1; s_rdata = 32'h1111_1111;
      end else if (s_valid) begin
        if (!tgt_never && cnt == tgt_delay) begin
          s_ready = 1'b1;
          s_rdata = tgt_fixed ? tgt_rdata : (s_addr ^ 32'h5A5A_0000);
        end else begin
          s_ready = 1'b0; s_rdata = 32'h0;
        end
        cnt++;
      end else begin
        cnt = 0; s_ready = 1'b0; s_rdata = 32'h0;
      end
    end
  end

  // Monitor: compares target requests on s_valid rise and master completions on ready.
  initial begin
    rsp_t r;
    req_t q;
    int   m;
    bit   prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        if (m0_ready && m1_ready) begin
          vectors++; miscompares++;
          $display("[TB] FAIL both_ready: got m0_ready=1 m1_ready=1, required at most one");
        end
        if (exp_rsp.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL unexpected_ready: got m0_ready=%0b m1_ready=%0b, required none", m0_ready, m1_ready);
        end else begin
          r = exp_rsp.pop_front();
          m = m1_ready ? 1 : 0;
          checkOutput("rsp_master", m, r.m);
          checkOutput("rsp_rdata", m ? m1_rdata : m0_rdata, r.rdata);
          if (r.cyc >= 0) checkOutput("rsp_cycle", cyc, r.cyc);
        end
      end
      if (s_valid && !prev_sv) begin
        if (exp_req.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL unexpected_request: got s_addr=0x%08h, required no request", s_addr);
        end else begin
          q = exp_req.pop_front();
          checkOutput("req_grant", grant, q.g);
          checkOutput("req_addr", s_addr, q.addr);
          checkOutput("req_wstrb", s_wstrb, q.wstrb);
          checkOutput("req_wdata", s_wdata, q.wdata);
        end
      end
      prev_sv = s_valid;
    end
  end

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_grant", grant, 1);
    checkOutput("reset_s_valid", s_valid, 0);
    checkOutput("reset_m0_ready", m0_ready, 0);
    checkOutput("reset_m1_ready", m1_ready, 0);
    checkOutput("reset_m0_rdata", m0_rdata, 0);
    checkOutput("reset_m1_rdata", m1_rdata, 0);
    checkOutput("reset_flag", timeout_flag, 0);
    checkOutput("reset_tmaster", timeout_master, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] contention after reset");
    tgt_fixed = 1'b0; tgt_delay = 1; tgt_never = 1'b0;
    expectReq(0, 32'h0300_0010, 4'h0, 32'h0); expectRsp(0, 32'h595A_0010, -1);
    expectReq(1, 32'h0300_0020, 4'h0, 32'h0); expectRsp(1, 32'h595A_0020, -1);
    expectReq(0, 32'h0300_0014, 4'h0, 32'h0); expectRsp(0, 32'h595A_0014, -1);
    expectReq(1, 32'h0300_0024, 4'h0, 32'h0); expectRsp(1, 32'h595A_0024, -1);
    expectReq(0, 32'h0300_0018, 4'h0, 32'h0); expectRsp(0, 32'h595A_0018, -1);
    expectReq(1, 32'h0300_0028, 4'h0, 32'h0); expectRsp(1, 32'h595A_0028, -1);
    fork
      begin
        applyStimulus(0, 32'h0300_0010, 4'h0, 32'h0);
        applyStimulus(0, 32'h0300_0014, 4'h0, 32'h0);
        applyStimulus(0, 32'h0300_0018, 4'h0, 32'h0);
      end
      begin
        applyStimulus(1, 32'h0300_0020, 4'h0, 32'h0);
        applyStimulus(1, 32'h0300_0024, 4'h0, 32'h0);
        applyStimulus(1, 32'h0300_0028, 4'h0, 32'h0);
      end
    join

    $display("[TB] single read");
    tgt_fixed = 1'b1; tgt_rdata = 32'h0000_00A5;
    expectReq(0, 32'h0300_0000, 4'h0, 32'h0);
    expectRsp(0, 32'h0000_00A5, cyc + 4);
    applyStimulus(0, 32'h0300_0000, 4'h0, 32'h0);
    checkOutput("done_s_valid", s_valid, 0);
    checkOutput("done_s_addr", s_addr, 0);

    $display("[TB] write pass-through");
    tgt_rdata = 32'h0000_0077;
    expectReq(1, 32'h0300_0004, 4'b0011, 32'h1234_5678);
    expectRsp(1, 32'h0000_0077, cyc + 4);
    applyStimulus(1, 32'h0300_0004, 4'b0011, 32'h1234_5678);

    $display("[TB] timeout on master 0");
    tgt_never = 1'b1;
    expectReq(0, 32'h0300_0008, 4'h0, 32'h0);
    expectRsp(0, 32'hDEAD_BEEF, cyc + 66);
    applyStimulus(0, 32'h0300_0008, 4'h0, 32'h0);
    checkOutput("to_flag", timeout_flag, 1);
    checkOutput("to_master", timeout_master, 0);
    @(negedge clk); tgt_late = 1'b1;
    @(negedge clk); tgt_late = 1'b0;
    @(posedge clk); #1;
    checkOutput("late_ready_rdata", m0_rdata, 32'hDEAD_BEEF);
    checkOutput("late_ready_flag", timeout_flag, 1);
    timeout_clr = 1'b1;
    @(posedge clk); #1;
    timeout_clr = 1'b0;
    checkOutput("clr_flag", timeout_flag, 0);

    $display("[TB] ready on the last allowed cycle");
    tgt_never = 1'b0; tgt_delay = 63; tgt_rdata = 32'h0000_0005;
    expectReq(0, 32'h0300_000C, 4'h0, 32'h0);
    expectRsp(0, 32'h0000_0005, cyc + 66);
    applyStimulus(0, 32'h0300_000C, 4'h0, 32'h0);
    checkOutput("edge_flag", timeout_flag, 0);

    $display("[TB] timeout on master 1 with clear held");
    tgt_never = 1'b1;
    timeout_clr = 1'b1;
    expectReq(1, 32'h0300_001C, 4'h0, 32'h0);
    expectRsp(1, 32'hDEAD_BEEF, cyc + 66);
    applyStimulus(1, 32'h0300_001C, 4'h0, 32'h0);
    checkOutput("set_wins_flag", timeout_flag, 1);
    checkOutput("to1_master", timeout_master, 1);
    @(posedge clk); #1;
    checkOutput("held_clr_flag", timeout_flag, 0);
    timeout_clr = 1'b0;

    $display("[TB] reset mid-transaction");
    expectReq(0, 32'h0300_0020, 4'h0, 32'h0);
    m0_valid = 1'b1; m0_addr = 32'h0300_0020; m0_wstrb = 4'h0; m0_wdata = 32'h0;
    repeat (5) @(posedge clk);
    #3;
    checkOutput("pre_reset_s_valid", s_valid, 1);
    resetn = 1'b0;
    #1;
    checkOutput("async_s_valid", s_valid, 0);
    checkOutput("async_m0_ready", m0_ready, 0);
    checkOutput("async_m1_ready", m1_ready, 0);
    checkOutput("async_grant", grant, 1);
    m0_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    tgt_never = 1'b0; tgt_delay = 1; tgt_fixed = 1'b0;
    checkOutput("post_reset_grant", grant, 1);
    expectReq(0, 32'h0300_0030, 4'h0, 32'h0); expectRsp(0, 32'h595A_0030, -1);
    expectReq(1, 32'h0300_0040, 4'h0, 32'h0); expectRsp(1, 32'h595A_0040, -1);
    fork
      applyStimulus(0, 32'h0300_0030, 4'h0, 32'h0);
      applyStimulus(1, 32'h0300_0040, 4'h0, 32'h0);
    join

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rsp_queue_drained", exp_rsp.size(), 0);
    checkOutput("req_queue_drained", exp_req.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
